pipo_load_arbiter: RTL and testbench
====================================

# pipo_load_arbiter

Round-robin arbiter that shares one parallel-in/parallel-out register among NREQ requesters. Each requester presents a data word and a request. The arbiter selects one, drives the shared register's data and load inputs for exactly one cycle, and acknowledges the winner. It sits directly in front of a `pipo` instance: `pipo_d` and `pipo_load` connect to that register's data and load inputs, and both blocks share `clk` and `res`.

## Interface
- `WIDTH`, 4, data width of the shared register.
- `NREQ`, 4, number of requesters; legal values 2, 4, 8.
- `IW`, $clog2(NREQ), index width; derived, never overridden.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `res`  in  1  reset, asynchronous and active-high.
- `req`  in  NREQ  request per requester; bit i belongs to requester i.
- `din`  in  NREQ*WIDTH  requester data; requester i drives bits [i*WIDTH +: WIDTH].
- `gnt`  out  NREQ  one-hot, one-cycle acknowledge to the winning requester.
- `pipo_d`  out  WIDTH  data to the shared register.
- `pipo_load`  out  1  load strobe to the shared register.
- `owner`  out  IW  index of the most recently granted requester.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: sample `req`. If any bit is set, choose the winner by round-robin starting at pointer `rr`. Latch the winner's `din` into `data_q` and its index into `idx_q`, then go to LOAD. If no bit is set, stay in IDLE.
  - LOAD: `pipo_load`=1, `pipo_d`=`data_q`, `gnt[idx_q]`=1. Set `rr` to (`idx_q`+1) mod NREQ and `owner` to `idx_q`. Go to HOLD unconditionally.
  - HOLD: `pipo_load`=0, `gnt`=0. Guard cycle that lets the winner drop `req`. Go to IDLE unconditionally.
- Round-robin rule: the winner is the first set bit of `req` at index `rr`, `rr`+1, …, wrapping from NREQ-1 to 0. Bit `rr` itself has highest priority.
- Data and index are captured in IDLE. If `req` or `din` changes after capture, the transfer still completes with the captured values.
- The handshake contract:
  - The requester holds `req` and `din` stable until it sees `gnt`.
  - The requester must deassert `req` in the cycle after `gnt`; otherwise it re-enters arbitration as a new request.
- Outside LOAD, `pipo_d` holds `data_q`. Its value is don't-care to the register because `pipo_load`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `req` or `din` to any output.
- Reset, asynchronous at any point including mid-transfer:
  - State goes to IDLE; `rr`=0, `owner`=0, `data_q`=0, `idx_q`=0.
  - `gnt`=0, `pipo_load`=0, `pipo_d`=0, `busy`=0.
  - A transfer in progress is abandoned with no `gnt` issued. The requester must keep requesting.
- Throughput: at most one transfer per 3 cycles.

## Timing
- Cycle numbering, with request sampled in IDLE at edge E0:
  - E0: IDLE→LOAD.
  - Cycle after E0: `pipo_load`=1 and `gnt` asserted.
  - Edge E1: the register captures `pipo_d`; FSM goes to HOLD.
  - E2: HOLD→IDLE.
  - E3: earliest next sample.
- Request-to-register-update latency: 2 rising edges (E0, E1). The register output changes after E1.
- `busy` is high in LOAD and HOLD and low in IDLE. It rises after E0 and falls after E2.
- `gnt`, `pipo_load` and the new `owner` value are asserted in the same cycle.
- `rr` updates at E1. Simultaneous requests are therefore served in rotating order, each pair 3 cycles apart.
- Reset deassertion: the first sample occurs at the first rising edge with `res`=0.

## Test plan
- Reset, then requester 2 alone with `din`=1001: `pipo_load`=1 one cycle after the sampling edge with `pipo_d`=1001, `gnt`=0100, `owner`=2; the `pipo` output reads 1001 after the next edge; `busy` high for exactly 2 cycles.
- All four requesters held high continuously after reset (`rr`=0): grants in order 0,1,2,3,0, spaced exactly 3 cycles apart; each `pipo_load` pulse carries that requester's `din`.
- Requester 1 granted, then `req`=1010 (requesters 1 and 3): requester 3 wins next (`rr`=2 skips the idle requester 2), then requester 1.
- Requester 0 changes `din` from 0011 to 1100 in the LOAD cycle: `pipo_d`=0011 is what gets loaded.
- `res` asserted during LOAD: `pipo_load` and `gnt` drop immediately, before the next edge; `busy`=0; `pipo` is not loaded; after release the same request is granted normally with `owner` starting from 0.
- Requester keeps `req` high after `gnt` while no one else requests: it is granted again 3 cycles later, a double write. This confirms the contract is the requester's responsibility.

Source files
------------

// File: rtl/pipo_load_arbiter.sv
// -----------------------------------------------------------------------------
// pipo_load_arbiter
//
// Round-robin arbiter that shares one parallel-in/parallel-out register among
// NREQ requesters. A request is sampled in IDLE, and the winner's data and index
// are captured. The arbiter then drives the register's load strobe for exactly
// one cycle (LOAD) and spends one guard cycle (HOLD) before it samples again.
// This allows at most one transfer every 3 cycles.
//
// Parameters
//   WIDTH  data width of the shared register
//   NREQ   number of requesters (2, 4 or 8)
//
// Ports
//   clk        in   system clock, rising edge
//   res        in   asynchronous active-high reset
//   req        in   [NREQ]        request, bit i = requester i
//   din        in   [NREQ*WIDTH]  requester i drives [i*WIDTH +: WIDTH]
//   gnt        out  [NREQ]        one-hot, one-cycle acknowledge (LOAD only)
//   pipo_d     out  [WIDTH]       data to the shared register (holds data_q)
//   pipo_load  out                load strobe to the shared register
//   owner      out  [IW]          index of the most recently granted requester
//   busy       out                high in LOAD and HOLD
//
// All outputs come from registered state only. No path runs from req/din to
// any output.
// -----------------------------------------------------------------------------
module pipo_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        pipo_d,
  output logic                    pipo_load,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  // Index width is derived from NREQ and is never set on its own.
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    rr_q,    rr_d;     // highest-priority requester index
  logic [IW-1:0]    owner_q, owner_d;  // last granted, committed at end of LOAD
  logic [IW-1:0]    idx_q,   idx_d;    // winner captured in IDLE
  logic [WIDTH-1:0] data_q,  data_d;   // winner's data captured in IDLE

  // Round-robin search result for the current req and rr_q.
  logic             pick_found;
  logic [IW-1:0]    pick_idx;

  // ---------------------------------------------------------------------------
  // Round-robin pick: the first set bit at rr, rr+1, ... The candidate index
  // wraps from NREQ-1 to 0 because NREQ is a power of two. Truncating to IW
  // bits therefore gives the modulo.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every variable written in a combinational block gets a default at
    // the top. A path that leaves a variable unassigned would infer a latch.
    pick_found = 1'b0;
    pick_idx   = rr_q;
    cand       = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_q + IW'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from the values they held before the edge.
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          // Capture now, so later changes on req/din cannot affect this transfer.
          idx_d   = pick_idx;
          data_d  = din[pick_idx*WIDTH +: WIDTH];
          state_d = LOAD;
        end
      end
      LOAD: begin
        rr_d    = idx_q + IW'(1);
        owner_d = idx_q;
        state_d = HOLD;
      end
      HOLD: begin
        // Guard cycle: the winner drops req before the next sample.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt       = '0;
    pipo_load = 1'b0;
    pipo_d    = data_q;
    busy      = (state_q != IDLE);
    // The new owner appears together with gnt and pipo_load. It is committed
    // into owner_q at the end of LOAD.
    owner     = owner_q;
    if (state_q == LOAD) begin
      gnt[idx_q] = 1'b1;
      pipo_load  = 1'b1;
      owner      = idx_q;
    end
  end

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for pipo_load_arbiter (WIDTH=4, NREQ=4).
//
// The reference model works at transfer level. A sample decides the winner,
// rotates the priority and names the owner at once. It then counts down two
// busy cycles, and the shared register takes the captured word after the
// first of those cycles. A stand-in for the downstream pipo register is
// driven from the DUT's pipo_d/pipo_load. Directed scenarios pin the model
// with literal expectations, and randomized traffic with random asynchronous
// resets follows.
// -----------------------------------------------------------------------------
module tb_pipo_load_arbiter;

  localparam int W = 4;
  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              res;
  logic [N-1:0]      req;
  logic [N*W-1:0]    din;
  logic [N-1:0]      gnt;
  logic [W-1:0]      pipo_d;
  logic              pipo_load;
  logic [IW-1:0]     owner;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  pipo_load_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .res       (res),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .pipo_d    (pipo_d),
    .pipo_load (pipo_load),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream pipo register. It shares clk and res.
  logic [W-1:0] pipo_q;
  always @(posedge clk or posedge res) begin
    if (res) pipo_q <= '0;
    else if (pipo_load) pipo_q <= pipo_d;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int           m_left  = 0;   // busy cycles remaining (2 = load cycle next)
  int           m_rr    = 0;
  int           m_owner = 0;
  int           m_idx   = 0;
  logic [W-1:0] m_data  = '0;
  logic [W-1:0] m_reg   = '0;

  function automatic int rr_pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_left = 0; m_rr = 0; m_owner = 0; m_idx = 0; m_data = '0; m_reg = '0;
    end else if (m_left == 2) begin
      m_reg  = m_data;
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (req != '0) begin
      m_idx   = rr_pick(req, m_rr);
      m_data  = din[m_idx*W +: W];
      m_owner = m_idx;
      m_rr    = (m_idx + 1) % N;
      m_left  = 2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: every outputs-stable point, away from the rising edge.
  always @(negedge clk) begin
    logic exp_load;
    exp_load = (m_left == 2);
    check("m_load",  32'(pipo_load), 32'(exp_load));
    check("m_gnt",   32'(gnt),       exp_load ? (32'd1 << m_idx) : 32'd0);
    check("m_pipod", 32'(pipo_d),    32'(m_data));
    check("m_owner", 32'(owner),     32'(m_owner));
    check("m_busy",  32'(busy),      32'(m_left != 0));
    check("m_reg",   32'(pipo_q),    32'(m_reg));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int           g_n;
  int           g_idx [16];
  int           g_cyc [16];
  logic [W-1:0] g_dat [16];
  int           g_own [16];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    res = 1'b0;
  endtask

  // Step until n grants are seen or the budget runs out, and record each grant.
  task automatic collect(input string name, input int n, input int budget);
    g_n = 0;
    for (int c = 0; c < budget && g_n < n; c++) begin
      step();
      if (gnt != '0) begin
        check({name, "_onehot"}, 32'($countones(gnt)), 32'd1);
        for (int i = 0; i < N; i++) if (gnt[i]) g_idx[g_n] = i;
        g_cyc[g_n] = c;
        g_dat[g_n] = pipo_d;
        g_own[g_n] = int'(owner);
        g_n++;
      end
    end
    check({name, "_count"}, 32'(g_n), 32'(n));
  endtask

  task automatic drain();
    req = '0;
    repeat (4) step();
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios, then random traffic
  // ---------------------------------------------------------------------------
  initial begin
    res = 1'b1;
    req = '0;
    din = '0;
    repeat (2) step();
    check("rst_gnt",   32'(gnt), 0);
    check("rst_load",  32'(pipo_load), 0);
    check("rst_pipod", 32'(pipo_d), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    res = 1'b0;

    // Requester 2 alone, din = 1001.
    req = 4'b0100; din = 16'h0900;
    step();
    check("t1_load",  32'(pipo_load), 1);
    check("t1_pipod", 32'(pipo_d), 32'h9);
    check("t1_gnt",   32'(gnt), 32'b0100);
    check("t1_owner", 32'(owner), 2);
    check("t1_busy0", 32'(busy), 1);
    req = '0;
    step();
    check("t1_reg",   32'(pipo_q), 32'h9);
    check("t1_load2", 32'(pipo_load), 0);
    check("t1_busy1", 32'(busy), 1);
    step();
    check("t1_busy2", 32'(busy), 0);
    drain();

    // All four requesters held high: grants 0,1,2,3,0 spaced 3 cycles apart.
    do_reset();
    din = 16'h7531; req = 4'hF;
    collect("t2", 5, 24);
    for (int k = 0; k < g_n; k++) begin
      check("t2_idx", 32'(g_idx[k]), 32'(k % 4));
      check("t2_dat", 32'(g_dat[k]), 32'((2 * (k % 4)) + 1));
      if (k > 0) check("t2_gap", 32'(g_cyc[k] - g_cyc[k-1]), 3);
    end
    drain();

    // Requester 1 granted, then 1010: requester 3 wins, then requester 1.
    do_reset();
    din = 16'hA5C3; req = 4'b0010;
    collect("t3a", 1, 6);
    if (g_n == 1) check("t3_first", 32'(g_idx[0]), 1);
    req = 4'b1010;
    collect("t3b", 2, 12);
    if (g_n == 2) begin
      check("t3_second", 32'(g_idx[0]), 3);
      check("t3_third",  32'(g_idx[1]), 1);
      check("t3_dat3",   32'(g_dat[0]), 32'hA);
      check("t3_gap",    32'(g_cyc[1] - g_cyc[0]), 3);
    end
    drain();

    // Requester 0 changes din in the LOAD cycle; the captured 0011 is loaded.
    do_reset();
    req = 4'b0001; din = 16'h0003;
    step();
    check("t4_load",  32'(pipo_load), 1);
    check("t4_pipod", 32'(pipo_d), 32'h3);
    din = 16'h000C; req = '0;
    step();
    check("t4_reg", 32'(pipo_q), 32'h3);
    drain();

    // Reset in LOAD: outputs drop before the next edge, and nothing is loaded.
    do_reset();
    req = 4'b0100; din = 16'h0600;
    step();
    check("t5_load_pre", 32'(pipo_load), 1);
    #2 res = 1'b1;
    #1;
    check("t5_load", 32'(pipo_load), 0);
    check("t5_gnt",  32'(gnt), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_pd",   32'(pipo_d), 0);
    step();
    check("t5_reg",  32'(pipo_q), 0);
    res = 1'b0;
    check("t5_owner0", 32'(owner), 0);
    collect("t5", 1, 6);
    if (g_n == 1) begin
      check("t5_idx", 32'(g_idx[0]), 2);
      check("t5_dat", 32'(g_dat[0]), 32'h6);
      check("t5_own", 32'(g_own[0]), 2);
    end
    step();
    check("t5_reg2", 32'(pipo_q), 32'h6);
    drain();

    // Requester keeps req high after gnt: it is granted again 3 cycles later.
    do_reset();
    req = 4'b0001; din = 16'h000E;
    collect("t6", 2, 10);
    if (g_n == 2) begin
      check("t6_idx0", 32'(g_idx[0]), 0);
      check("t6_idx1", 32'(g_idx[1]), 0);
      check("t6_gap",  32'(g_cyc[1] - g_cyc[0]), 3);
    end
    drain();

    // Random traffic with occasional mid-cycle asynchronous reset pulses.
    for (int c = 0; c < 1500; c++) begin
      step();
      if ($urandom_range(0, 63) == 0) begin
        res = 1'b1;
        #1 res = 1'b0;
      end
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
      din = (N*W)'($urandom);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
